iir_biquad_tdm: RTL and testbench
=================================

// Module: iir_biquad_tdm
// PURPOSE
//  Programmable second-order (biquad) IIR filter, Direct Form I, signed fixed point, for the FIR/IIR filter library.
//  Time-multiplexes CH_CNT independent channels through one shared multiplier/accumulator, under FSM control.
//  Valid/ready streaming on input and output; rounds and saturates the result.
//  Successor to the fixed 8-bit Q4.4 IIR: width, fractional point and channel count are parametrised.
// PARAMETERS
//  DW      8  sample width, signed two's complement, Q(DW-FRAC).FRAC
//  CW      8  coefficient width, signed, same FRAC as samples
//  FRAC    4  fractional bits (1..min(DW,CW)-1)
//  CH_CNT  2  number of channels (>=1); CHW = max(1,$clog2(CH_CNT))
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous active-low reset
//  clr        in   1       sync pulse: zero all channel history, abort in-flight sample
//  b0,b1,b2   in   CW      feed-forward coefficients (signed)
//  a1,a2      in   CW      feedback coefficients (signed), subtracted
//  in_valid   in   1       input sample valid
//  in_ready   out  1       block can accept a sample
//  in_ch      in   CHW     channel index of input sample
//  x          in   DW      input sample
//  out_valid  out  1       result valid
//  out_ready  in   1       sink accepts result
//  out_ch     out  CHW     channel index of result
//  y          out  DW      filtered, rounded, saturated output
// BEHAVIOUR
//  - y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2], per channel; history is the saturated y.
//  - Reset (rst=0, async): FSM=IDLE, in_ready=1, out_valid=0, y=0, out_ch=0, all history=0.
//  - Accept on posedge with in_valid&in_ready. Capture x, in_ch and all five coefficients.
//    Coefficient changes mid-sample have no effect on that sample.
//  - FSM: IDLE -(accept)-> MAC0..MAC4 (one product per cycle: b0x, b1x1, b2x2, -a1y1, -a2y2) -> OUT -(out_ready)-> IDLE.
//  - in_ready=1 only in IDLE; no overlap between samples. out_valid=1 only in OUT.
//  - Latency: out_valid rises on the 6th posedge after the accept edge. Max throughput 1 sample / 7 cycles.
//  - OUT holds y/out_ch stable until out_ready. out_ready is ignored when out_valid=0.
//  - Arithmetic: products are DW+CW bits. Accumulator ACC_W = DW+CW+3 bits, no intermediate overflow.
//    Result = (acc + 2^(FRAC-1)) >>> FRAC (round half up).
//    Saturate to [-2^(DW-1), 2^(DW-1)-1].
//  - History update for channel out_ch (x2<=x1, x1<=x, y2<=y1, y1<=y) on the MAC4->OUT edge, independent of backpressure.
//    All other channels remain untouched.
//  - in_ch >= CH_CNT: sample accepted, passes through the MAC, output y=0, no history update.
//  - clr=1: all history=0, FSM->IDLE, out_valid->0 next edge; clr wins over a simultaneous accept/out handshake.
//  - rst mid-operation: immediate return to reset state; the partial result is discarded.
// STRUCTURE
//  - Package iir_pkg: state enum (IDLE, MAC0..MAC4, OUT), ACC_W function, sat/round function.
//  - Sub-module iir_hist_bank: per-channel x1,x2,y1,y2 register array; one read port (in_ch) and one write port.
//    Reset and clr zero the whole array.
//  - Top: FSM, coefficient/operand mux, single signed multiplier, accumulator, round/saturate stage.
// TESTING (DW=8, FRAC=4, CH_CNT=2)
//  1. Gain: b0=8'h08 (0.5), others 0, x=8'h20 ch0 -> y=8'h10 at accept+6.
//  2. Recursion: b0=8'h10, a1=8'hF8 (-0.5), a2=0. Impulse x=8'h10 then 0s on ch0 -> y=10,08,04,02,01,01 (hex).
//  3. Saturation: b0=8'h7F, x=8'h7F -> y=8'h7F; x=8'h80 -> y=8'h80.
//     Rounding: b0=8'h08, x=8'h01 -> y=8'h01.
//  4. Channel isolation: interleave test 2 on ch0 with x=0 on ch1 -> ch1 y stays 0; ch0 sequence unchanged.
//  5. Backpressure: hold out_ready=0 for 10 cycles -> y and out_valid stable, in_ready=0; release -> IDLE next edge.
//  6. clr mid-MAC2, then rst low mid-MAC3 -> out_valid=0, history 0; impulse response restarts from 8'h10.

Source files
------------

// File: rtl/iir_pkg.sv
// Package: iir_pkg
// Shared definitions for the time-multiplexed biquad IIR filter.
//  - state_t    : controller states (IDLE, one state per MAC product, OUT)
//  - acc_width  : accumulator width needed for five DW x CW products
//  - ch_width   : channel index width, at least one bit
//  - round_sat  : round-half-up, arithmetic shift and saturation of the
//                 accumulator, carried out on a 64-bit signed value
package iir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    MAC3,
    MAC4,
    OUT
  } state_t;

  // Five products of DW+CW bits need three guard bits to never overflow.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + 3;
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Adds half an LSB of the output grid, drops the fractional bits with an
  // arithmetic shift (so ties go towards +inf) and clamps to the signed
  // dw-bit range. The caller narrows the result to dw bits.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int frac,
                                                   input int dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) begin
      return hi;
    end else if (r < lo) begin
      return lo;
    end else begin
      return r;
    end
  endfunction

endpackage

// File: rtl/iir_hist_bank.sv
// Module: iir_hist_bank
// Per-channel Direct Form I history: x[n-1], x[n-2], y[n-1], y[n-2].
// Ports:
//  clk, rst          clock, asynchronous active-low reset
//  clr               synchronous clear of every channel
//  rd_ch             channel whose history is presented on rd_*
//  rd_ok             rd_ch names an existing channel
//  rd_x1..rd_y2      history of rd_ch (zero when rd_ch is out of range)
//  wr_en, wr_ch      shift new sample/result into channel wr_ch
//  wr_x, wr_y        newest input sample and saturated output
module iir_hist_bank
  import iir_pkg::*;
#(
  parameter int DW     = 8,
  parameter int CH_CNT = 2,
  parameter int CHW    = ch_width(CH_CNT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [CHW-1:0] rd_ch,
  output logic           rd_ok,
  output logic [DW-1:0]  rd_x1,
  output logic [DW-1:0]  rd_x2,
  output logic [DW-1:0]  rd_y1,
  output logic [DW-1:0]  rd_y2,
  input  logic           wr_en,
  input  logic [CHW-1:0] wr_ch,
  input  logic [DW-1:0]  wr_x,
  input  logic [DW-1:0]  wr_y
);

  logic [DW-1:0] x1_mem [CH_CNT];
  logic [DW-1:0] x2_mem [CH_CNT];
  logic [DW-1:0] y1_mem [CH_CNT];
  logic [DW-1:0] y2_mem [CH_CNT];

  // When CH_CNT fills the index space every index is a real channel.
  generate
    if (CH_CNT == (2 ** CHW)) begin : g_full
      assign rd_ok = 1'b1;
    end else begin : g_partial
      assign rd_ok = (rd_ch < CHW'(CH_CNT));
    end
  endgenerate

  always_comb begin
    rd_x1 = '0;
    rd_x2 = '0;
    rd_y1 = '0;
    rd_y2 = '0;
    if (rd_ok) begin
      rd_x1 = x1_mem[rd_ch];
      rd_x2 = x2_mem[rd_ch];
      rd_y1 = y1_mem[rd_ch];
      rd_y2 = y2_mem[rd_ch];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH_CNT; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < CH_CNT; i++) begin
        x1_mem[i] <= '0;
        x2_mem[i] <= '0;
        y1_mem[i] <= '0;
        y2_mem[i] <= '0;
      end
    end else if (wr_en) begin
      x2_mem[wr_ch] <= x1_mem[wr_ch];
      x1_mem[wr_ch] <= wr_x;
      y2_mem[wr_ch] <= y1_mem[wr_ch];
      y1_mem[wr_ch] <= wr_y;
    end
  end

endmodule

// File: rtl/iir_biquad_tdm.sv
// Module: iir_biquad_tdm
// Programmable Direct Form I biquad, signed fixed point Q(DW-FRAC).FRAC,
// shared by CH_CNT channels through one multiplier and accumulator.
//   y[n] = b0*x[n] + b1*x[n-1] + b2*x[n-2] - a1*y[n-1] - a2*y[n-2]
// Each accepted sample takes one cycle per product (MAC0..MAC4), then the
// rounded/saturated result is held in OUT until out_ready.
// Ports:
//  clk, rst            clock, asynchronous active-low reset
//  clr                 zero all history and abort the sample in flight
//  b0, b1, b2          feed-forward coefficients (signed)
//  a1, a2              feedback coefficients (signed, subtracted)
//  in_valid/in_ready   input handshake; in_ch selects the channel, x the sample
//  out_valid/out_ready output handshake; out_ch and y carry the result
module iir_biquad_tdm
  import iir_pkg::*;
#(
  parameter int DW     = 8,
  parameter int CW     = 8,
  parameter int FRAC   = 4,
  parameter int CH_CNT = 2,
  parameter int CHW    = ch_width(CH_CNT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic [CW-1:0]  b0,
  input  logic [CW-1:0]  b1,
  input  logic [CW-1:0]  b2,
  input  logic [CW-1:0]  a1,
  input  logic [CW-1:0]  a2,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  y
);

  localparam int ACC_W = acc_width(DW, CW);
  localparam int PW    = DW + CW;

  state_t state, state_nxt;

  logic signed [DW-1:0]    x_q;
  logic [CHW-1:0]          ch_q;
  logic signed [CW-1:0]    b0_q, b1_q, b2_q, a1_q, a2_q;
  logic signed [ACC_W-1:0] acc, acc_base, acc_nxt, prod_ext;
  logic signed [CW-1:0]    coef_sel;
  logic signed [DW-1:0]    op_sel;
  logic                    sub_sel;
  logic signed [PW-1:0]    prod;
  logic signed [DW-1:0]    y_res;
  logic [DW-1:0]           y_q;
  logic [CHW-1:0]          out_ch_q;
  logic                    accept;
  logic                    hist_wr;
  logic                    ch_ok;
  logic [DW-1:0]           h_x1, h_x2, h_y1, h_y2;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign accept    = in_ready & in_valid & ~clr;
  assign y         = y_q;
  assign out_ch    = out_ch_q;

  // History is written as the last product lands, whether or not the sink
  // is ready; out-of-range channels never touch the bank.
  assign hist_wr = (state == MAC4) & ~clr & ch_ok;

  iir_hist_bank #(
    .DW     (DW),
    .CH_CNT (CH_CNT),
    .CHW    (CHW)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .rd_ch (ch_q),
    .rd_ok (ch_ok),
    .rd_x1 (h_x1),
    .rd_x2 (h_x2),
    .rd_y1 (h_y1),
    .rd_y2 (h_y2),
    .wr_en (hist_wr),
    .wr_ch (ch_q),
    .wr_x  (x_q),
    .wr_y  (y_res)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // clr overrides any handshake and always lands the controller in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MAC0;
      MAC0:    state_nxt = MAC1;
      MAC1:    state_nxt = MAC2;
      MAC2:    state_nxt = MAC3;
      MAC3:    state_nxt = MAC4;
      MAC4:    state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
    end
  end

  // One coefficient/operand pair per MAC state; feedback terms subtract.
  always_comb begin
    coef_sel = b0_q;
    op_sel   = x_q;
    sub_sel  = 1'b0;
    case (state)
      MAC1: begin
        coef_sel = b1_q;
        op_sel   = h_x1;
      end
      MAC2: begin
        coef_sel = b2_q;
        op_sel   = h_x2;
      end
      MAC3: begin
        coef_sel = a1_q;
        op_sel   = h_y1;
        sub_sel  = 1'b1;
      end
      MAC4: begin
        coef_sel = a2_q;
        op_sel   = h_y2;
        sub_sel  = 1'b1;
      end
      default: ;
    endcase
  end

  // Negation happens at accumulator width, so even the most negative
  // product is subtracted exactly. MAC0 starts a fresh sum.
  always_comb begin
    prod     = PW'(coef_sel) * PW'(op_sel);
    prod_ext = ACC_W'(prod);
    acc_base = (state == MAC0) ? '0 : acc;
    acc_nxt  = sub_sel ? (acc_base - prod_ext) : (acc_base + prod_ext);
    y_res    = DW'(round_sat(64'(acc_nxt), FRAC, DW));
  end

  // Sample, channel and coefficient snapshot so later input changes cannot
  // disturb the sample being computed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q  <= '0;
      ch_q <= '0;
      b0_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
    end else if (accept) begin
      x_q  <= x;
      ch_q <= in_ch;
      b0_q <= b0;
      b1_q <= b1;
      b2_q <= b2;
      a1_q <= a1;
      a2_q <= a2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if ((state != IDLE) && (state != OUT)) begin
      acc <= acc_nxt;
    end
  end

  // Result register: loaded once as MAC4 finishes and held through OUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q      <= '0;
      out_ch_q <= '0;
    end else if ((state == MAC4) && !clr) begin
      y_q      <= ch_ok ? y_res : '0;
      out_ch_q <= ch_q;
    end
  end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Testbench: tb_iir_biquad_tdm
// Directed vectors for iir_biquad_tdm (DW=8, CW=8, FRAC=4, CH_CNT=2) with
// hand-computed expected outputs: gain, recursion, saturation, rounding,
// channel isolation, backpressure, clear and asynchronous reset.
module tb_iir_biquad_tdm;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [7:0] b0, b1, b2, a1, a2;
  logic       in_valid;
  logic       in_ready;
  logic [0:0] in_ch;
  logic [7:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [0:0] out_ch;
  logic [7:0] y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iir_biquad_tdm #(
    .DW     (8),
    .CW     (8),
    .FRAC   (4),
    .CH_CNT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .a1        (a1),
    .a2        (a2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .y         (y)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clrPulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Waits (bounded) for in_ready, presents one sample, returns just after
  // the accept edge.
  task automatic acceptSample(input logic [0:0] ch, input logic [7:0] xv);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    in_ch    = ch;
    x        = xv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counting the accept edge as edge 1, out_valid must still be low after
  // edge 5 and high after edge 6.
  task automatic collectResult(input string tag, input logic [7:0] exp_y,
                               input logic [0:0] exp_ch);
    repeat (4) @(posedge clk);
    #1;
    checkOutput({tag, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_y"}, 32'(y), 32'(exp_y));
    checkOutput({tag, "_ch"}, 32'(out_ch), 32'(exp_ch));
  endtask

  task automatic applyStimulus(input string tag, input logic [0:0] ch,
                               input logic [7:0] xv, input logic [7:0] exp_y);
    acceptSample(ch, xv);
    collectResult(tag, exp_y, ch);
  endtask

  // Recursion b0=1.0, a1=-0.5: y halves each step with round-half-up.
  logic [7:0] rec_x   [6] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] rec_y   [6] = '{8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h01};
  logic [0:0] iso_ch  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] iso_x   [9] = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] iso_y   [9] = '{8'h10, 8'h00, 8'h08, 8'h00, 8'h04, 8'h00, 8'h02, 8'h00, 8'h01};

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    b0        = 8'h00;
    b1        = 8'h00;
    b2        = 8'h00;
    a1        = 8'h00;
    a2        = 8'h00;
    in_valid  = 1'b0;
    in_ch     = 1'b0;
    x         = 8'h00;
    out_ready = 1'b1;

    // Reset state
    #3 rst = 1'b0;
    #9;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Gain 0.5; b0 changes after accept must not affect the sample
    $display("[TB] gain");
    clrPulse();
    b0 = 8'h08;
    acceptSample(1'b0, 8'h20);
    b0 = 8'h40;
    collectResult("gain", 8'h10, 1'b0);

    // Saturation and rounding
    $display("[TB] saturation and rounding");
    b0 = 8'h7F;
    applyStimulus("sat_pos", 1'b0, 8'h7F, 8'h7F);
    applyStimulus("sat_neg", 1'b0, 8'h80, 8'h80);
    b0 = 8'h08;
    applyStimulus("round_up", 1'b0, 8'h01, 8'h01);
    applyStimulus("round_neg_half", 1'b1, 8'hFF, 8'h00);

    // Recursion on ch0
    $display("[TB] recursion");
    clrPulse();
    b0 = 8'h10;
    a1 = 8'hF8;
    for (int i = 0; i < 6; i++) begin
      applyStimulus($sformatf("rec%0d", i), 1'b0, rec_x[i], rec_y[i]);
    end

    // Channel isolation: ch0 impulse interleaved with ch1 zeros
    $display("[TB] channel isolation");
    clrPulse();
    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("iso%0d", i), iso_ch[i], iso_x[i], iso_y[i]);
    end

    // Backpressure: result held 10 cycles while a new sample waits
    $display("[TB] backpressure");
    clrPulse();
    b0 = 8'h08;
    a1 = 8'h00;
    out_ready = 1'b0;
    acceptSample(1'b1, 8'h40);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp_first_valid", 32'(out_valid), 32'd1);
    in_ch    = 1'b0;
    x        = 8'h7F;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_y%0d", i), 32'(y), 32'h20);
      checkOutput($sformatf("bp_ch%0d", i), 32'(out_ch), 32'd1);
      checkOutput($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("bp_no_ghost", 32'(out_valid), 32'd0);

    // clr during MAC2, then reset during MAC3
    $display("[TB] clear and reset abort");
    b0 = 8'h10;
    a1 = 8'hF8;
    clrPulse();
    applyStimulus("pre_clr", 1'b0, 8'h10, 8'h10);
    acceptSample(1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checkOutput("clr_out_valid", 32'(out_valid), 32'd0);
    checkOutput("clr_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("clr_aborted", 32'(out_valid), 32'd0);
    applyStimulus("post_clr_hist", 1'b0, 8'h00, 8'h00);

    applyStimulus("pre_rst", 1'b1, 8'h10, 8'h10);
    acceptSample(1'b1, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("arst_y", 32'(y), 32'd0);
    checkOutput("arst_out_ch", 32'(out_ch), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus("post_rst_hist", 1'b1, 8'h00, 8'h00);
    applyStimulus("restart0", 1'b0, 8'h10, 8'h10);
    applyStimulus("restart1", 1'b0, 8'h00, 8'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
